// File: rtl/ccip_receiver.sv
// ---------------------------------------------------------------------------
// ccip_receiver_pkg
//   Minimal CCI-P type set used by the Rx path.  Field layout follows the
//   CCI-P channel 0 request/response headers, so this block keeps the same
//   port shapes as the rest of the CPU-NIC interface.  RpcIf is the RPC
//   record that the CPU writes into the low bits of each ring cache line.
// ---------------------------------------------------------------------------
package ccip_receiver_pkg;

    typedef logic [41:0]  t_ccip_clAddr;
    typedef logic [15:0]  t_ccip_mdata;
    typedef logic [511:0] t_ccip_clData;

    typedef enum logic [1:0] {
        eVC_VA  = 2'b00,
        eVC_VL0 = 2'b01,
        eVC_VH0 = 2'b10,
        eVC_VH1 = 2'b11
    } t_ccip_vc;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'b00,
        eCL_LEN_2 = 2'b01,
        eCL_LEN_4 = 2'b11
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eREQ_RDLINE_I = 4'h0,
        eREQ_RDLINE_S = 4'h1
    } t_ccip_c0_req;

    typedef enum logic [3:0] {
        eRSP_RDLINE = 4'h0,
        eRSP_UMSG   = 4'h4
    } t_ccip_c0_rsp;

    typedef struct packed {
        t_ccip_vc     vc_sel;
        logic [1:0]   rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c0_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic [1:0]   rsvd0;
        logic [1:0]   cl_num;
        t_ccip_c0_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        t_ccip_clData       data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic [31:0] rpc_id;
        logic [31:0] arg;
    } RpcIf;

endpackage

// ---------------------------------------------------------------------------
// ccip_receiver
//   Rx path of the CPU-NIC interface.  Polls per-flow ring buffers in host
//   memory round-robin with single-line reads on CCI-P channel 0, detects
//   new entries through a per-flow phase bit (line bit 511) and hands each
//   new RPC downstream together with its flow id.
//
//   Ports:
//     clk, resetn          clock, asynchronous active-low reset
//     number_of_flows      index of the highest active flow
//     rx_base_addr         line address of flow 0, slot 0
//     start                enables polling
//     sRx_c0TxAlmFull      channel 0 request back-pressure
//     sTx_c0               registered read request
//     sRx_c0               read responses
//     rpc_out              received RPC (low bits of the ring line)
//     rpc_out_valid        rpc_out / rpc_flow_id_out valid
//     rpc_flow_id_out      flow the RPC came from
//     rpc_out_ready        downstream accepts
//     error                sticky: unexpected or mis-tagged read response
// ---------------------------------------------------------------------------
module ccip_receiver
    import ccip_receiver_pkg::*;
#(
    parameter int NIC_ID            = 0,
    parameter int LMAX_NUM_OF_FLOWS = 1,
    parameter int LRING_SLOTS       = 3
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [LMAX_NUM_OF_FLOWS-1:0] number_of_flows,
    input  t_ccip_clAddr                 rx_base_addr,
    input  logic                         start,
    input  logic                         sRx_c0TxAlmFull,
    output t_if_ccip_c0_Tx               sTx_c0,
    input  t_if_ccip_c0_Rx               sRx_c0,
    output RpcIf                         rpc_out,
    output logic                         rpc_out_valid,
    output logic [LMAX_NUM_OF_FLOWS-1:0] rpc_flow_id_out,
    input  logic                         rpc_out_ready,
    output logic                         error
);

    localparam int MAX_RX_FLOWS = 2 ** LMAX_NUM_OF_FLOWS;
    localparam int FLOW_TAG_W   = 12;

    localparam logic [1:0] RX_IDLE    = 2'd0;
    localparam logic [1:0] RX_WAIT    = 2'd1;
    localparam logic [1:0] RX_DELIVER = 2'd2;

    logic [1:0]                   state;
    logic [LMAX_NUM_OF_FLOWS-1:0] cur_flow;
    logic [LMAX_NUM_OF_FLOWS-1:0] next_flow;
    logic [3:0]                   seq;
    t_ccip_mdata                  tag_q;
    t_ccip_mdata                  cur_tag;
    t_ccip_clAddr                 slot_addr;
    logic [LRING_SLOTS-1:0]       head [MAX_RX_FLOWS];
    logic [MAX_RX_FLOWS-1:0]      phase;
    logic                         rsp_rdline;
    logic                         unused_ok;

    // Round-robin advance.  Using >= rather than == means a flow count that
    // shrinks underneath the current pointer still wraps back to flow 0.
    always_comb begin
        next_flow = cur_flow + 1'b1;
        if (cur_flow >= number_of_flows) begin
            next_flow = '0;
        end
    end

    // Address of the slot the current flow is expected to fill next, and the
    // tag that makes the matching response identifiable.
    always_comb begin
        slot_addr  = rx_base_addr
                   + (t_ccip_clAddr'(cur_flow) << LRING_SLOTS)
                   + t_ccip_clAddr'(head[cur_flow]);
        cur_tag    = {seq, FLOW_TAG_W'(cur_flow)};
        rsp_rdline = sRx_c0.rspValid && (sRx_c0.hdr.resp_type == eRSP_RDLINE);
    end

    // Poll/deliver sequencer.  Only one read is ever in flight, so the tag
    // of that read is kept in tag_q and every RDLINE response in RX_WAIT is
    // compared against it.  Ring head and phase advance only when the RPC
    // is actually accepted downstream; the phase flips each time a ring
    // wraps so stale lines from the previous lap read as empty.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= RX_IDLE;
            cur_flow        <= '0;
            seq             <= '0;
            tag_q           <= '0;
            sTx_c0          <= '0;
            rpc_out         <= '0;
            rpc_out_valid   <= 1'b0;
            rpc_flow_id_out <= '0;
            phase           <= '1;
            for (int f = 0; f < MAX_RX_FLOWS; f++) begin
                head[f] <= '0;
            end
        end else begin
            sTx_c0.valid <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (start && !sRx_c0TxAlmFull) begin
                        sTx_c0.valid <= 1'b1;
                        sTx_c0.hdr   <= '{vc_sel:   eVC_VH0,
                                          rsvd1:    2'b00,
                                          cl_len:   eCL_LEN_1,
                                          req_type: eREQ_RDLINE_I,
                                          rsvd0:    6'b000000,
                                          address:  slot_addr,
                                          mdata:    cur_tag};
                        tag_q        <= cur_tag;
                        seq          <= seq + 1'b1;
                        state        <= RX_WAIT;
                    end
                end
                RX_WAIT: begin
                    if (rsp_rdline && (sRx_c0.hdr.mdata == tag_q)) begin
                        if (sRx_c0.data[511] == phase[cur_flow]) begin
                            rpc_out         <= sRx_c0.data[$bits(RpcIf)-1:0];
                            rpc_flow_id_out <= cur_flow;
                            rpc_out_valid   <= 1'b1;
                            state           <= RX_DELIVER;
                        end else begin
                            cur_flow <= next_flow;
                            state    <= RX_IDLE;
                        end
                    end
                end
                RX_DELIVER: begin
                    if (rpc_out_ready) begin
                        rpc_out_valid  <= 1'b0;
                        head[cur_flow] <= head[cur_flow] + 1'b1;
                        if (&head[cur_flow]) begin
                            phase[cur_flow] <= ~phase[cur_flow];
                        end
                        cur_flow <= next_flow;
                        state    <= RX_IDLE;
                    end
                end
                default: begin
                    state <= RX_IDLE;
                end
            endcase
        end
    end

    // Sticky error: any RDLINE response we did not ask for (wrong tag, or
    // arriving while no read is outstanding).  Cleared only by reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            error <= 1'b0;
        end else if (rsp_rdline && ((state != RX_WAIT) || (sRx_c0.hdr.mdata != tag_q))) begin
            error <= 1'b1;
        end
    end

    // Response fields and the instance id that the datapath does not use.
    assign unused_ok = ^{sRx_c0, 32'(NIC_ID)};

endmodule

// File: tb/tb_ccip_receiver.sv
// ---------------------------------------------------------------------------
// tb_ccip_receiver
//   Directed self-checking bench for ccip_receiver.  The bench plays host
//   memory: it holds the ring contents, answers each read after a chosen
//   latency and keeps its own model of head/phase/sequence to predict the
//   addresses, tags and deliveries.
// ---------------------------------------------------------------------------
module tb_ccip_receiver;
    import ccip_receiver_pkg::*;

    localparam int LFLOWS = 1;
    localparam int LSLOTS = 3;
    localparam int SLOTS  = 2 ** LSLOTS;

    logic               clk;
    logic               resetn;
    logic [LFLOWS-1:0]  number_of_flows;
    t_ccip_clAddr       rx_base_addr;
    logic               start;
    logic               sRx_c0TxAlmFull;
    t_if_ccip_c0_Tx     sTx_c0;
    t_if_ccip_c0_Rx     sRx_c0;
    RpcIf               rpc_out;
    logic               rpc_out_valid;
    logic [LFLOWS-1:0]  rpc_flow_id_out;
    logic               rpc_out_ready;
    logic               error;

    int checks = 0;
    int errors = 0;

    // Host memory image and the bench's model of receiver progress.
    bit          mem_bit [2][SLOTS];
    logic [63:0] mem_rpc [2][SLOTS];
    int          exp_head [2];
    bit          exp_phase [2];
    logic [3:0]  exp_seq;
    int          exp_flow;

    ccip_receiver #(
        .NIC_ID            (0),
        .LMAX_NUM_OF_FLOWS (LFLOWS),
        .LRING_SLOTS       (LSLOTS)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .number_of_flows (number_of_flows),
        .rx_base_addr    (rx_base_addr),
        .start           (start),
        .sRx_c0TxAlmFull (sRx_c0TxAlmFull),
        .sTx_c0          (sTx_c0),
        .sRx_c0          (sRx_c0),
        .rpc_out         (rpc_out),
        .rpc_out_valid   (rpc_out_valid),
        .rpc_flow_id_out (rpc_flow_id_out),
        .rpc_out_ready   (rpc_out_ready),
        .error           (error)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so a stuck run still terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one channel 0 response for exactly one cycle.
    task automatic applyStimulus(input logic [15:0] mdata, input t_ccip_c0_rsp rtype,
                                 input bit line_bit, input logic [63:0] payload);
        sRx_c0                = '0;
        sRx_c0.rspValid       = 1'b1;
        sRx_c0.hdr.resp_type  = rtype;
        sRx_c0.hdr.mdata      = mdata;
        sRx_c0.data[511]      = line_bit;
        sRx_c0.data[63:0]     = payload;
        @(negedge clk);
        sRx_c0                = '0;
    endtask

    task automatic resetModel();
        exp_head  = '{0, 0};
        exp_phase = '{1'b1, 1'b1};
        exp_seq   = 4'h0;
        exp_flow  = 0;
    endtask

    task automatic clearMemory();
        for (int f = 0; f < 2; f++) begin
            for (int s = 0; s < SLOTS; s++) begin
                mem_bit[f][s] = 1'b0;
                mem_rpc[f][s] = 64'h0;
            end
        end
    endtask

    // Waits (bounded) for a read request and checks its fixed header fields.
    task automatic waitRead(output logic [41:0] addr, output logic [15:0] md, output bit ok);
        ok   = 1'b0;
        addr = '0;
        md   = '0;
        for (int i = 0; i < 50; i++) begin
            if (sTx_c0.valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checkOutput("rd_timeout", 64'd0, 64'd1);
            return;
        end
        addr = sTx_c0.hdr.address;
        md   = sTx_c0.hdr.mdata;
        checkOutput("rd_req_type", 64'(sTx_c0.hdr.req_type), 64'(eREQ_RDLINE_I));
        checkOutput("rd_vc_sel",   64'(sTx_c0.hdr.vc_sel),   64'(eVC_VH0));
        checkOutput("rd_cl_len",   64'(sTx_c0.hdr.cl_len),   64'(eCL_LEN_1));
    endtask

    // One full visit: read, memory response, optional delivery with an
    // optional stretch of downstream back-pressure.
    task automatic visit(input bit expect_deliver, input int latency, input int hold);
        logic [41:0] addr;
        logic [15:0] md;
        bit          ok;
        logic [63:0] payload;
        bit          line_bit;
        int          flow;
        flow = exp_flow;
        waitRead(addr, md, ok);
        if (!ok) return;
        checkOutput("rd_addr", 64'(addr),
                    64'(rx_base_addr + 42'(flow * SLOTS + exp_head[flow])));
        checkOutput("rd_mdata", 64'(md), 64'({exp_seq, 12'(flow)}));
        exp_seq = exp_seq + 4'h1;
        @(negedge clk);
        checkOutput("rd_single_cycle", 64'(sTx_c0.valid), 64'd0);
        repeat (latency - 1) @(negedge clk);
        payload  = mem_rpc[flow][exp_head[flow]];
        line_bit = mem_bit[flow][exp_head[flow]];
        if (hold > 0) rpc_out_ready = 1'b0;
        applyStimulus(md, eRSP_RDLINE, line_bit, payload);
        if (expect_deliver) begin
            checkOutput("rpc_valid",   64'(rpc_out_valid),   64'd1);
            checkOutput("rpc_data",    64'(rpc_out),         payload);
            checkOutput("rpc_flow_id", 64'(rpc_flow_id_out), 64'(flow));
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                checkOutput("bp_valid_held", 64'(rpc_out_valid), 64'd1);
                checkOutput("bp_data_stable", 64'(rpc_out), payload);
                checkOutput("bp_no_read", 64'(sTx_c0.valid), 64'd0);
            end
            rpc_out_ready = 1'b1;
            @(negedge clk);
            checkOutput("rpc_handshake", 64'(rpc_out_valid), 64'd0);
            exp_head[flow] = (exp_head[flow] + 1) % SLOTS;
            if (exp_head[flow] == 0) exp_phase[flow] = ~exp_phase[flow];
        end else begin
            checkOutput("rpc_none", 64'(rpc_out_valid), 64'd0);
        end
        exp_flow = (flow >= int'(number_of_flows)) ? 0 : flow + 1;
    endtask

    initial begin
        logic [41:0] addr;
        logic [15:0] md;
        bit          ok;

        resetn          = 1'b0;
        number_of_flows = '0;
        rx_base_addr    = 42'h1000;
        start           = 1'b0;
        sRx_c0TxAlmFull = 1'b0;
        sRx_c0          = '0;
        rpc_out_ready   = 1'b1;
        clearMemory();
        resetModel();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        $display("[TB] reset values");
        checkOutput("rst_tx_valid",  64'(sTx_c0.valid),    64'd0);
        checkOutput("rst_tx_hdr",    64'(sTx_c0.hdr),      64'd0);
        checkOutput("rst_rpc_out",   64'(rpc_out),         64'd0);
        checkOutput("rst_rpc_valid", 64'(rpc_out_valid),   64'd0);
        checkOutput("rst_flow_id",   64'(rpc_flow_id_out), 64'd0);
        checkOutput("rst_error",     64'(error),           64'd0);

        // Single flow: slot 0 delivers 0xA5, slot 1 is still empty.
        $display("[TB] single flow and ring wrap");
        mem_bit[0][0] = 1'b1;
        mem_rpc[0][0] = 64'hA5;
        start = 1'b1;
        visit(1'b1, 3, 0);
        visit(1'b0, 2, 0);
        // Fill the rest of the lap; slots 1..7 deliver and the ring wraps.
        for (int s = 1; s < SLOTS; s++) begin
            mem_bit[0][s] = 1'b1;
            mem_rpc[0][s] = 64'h10 + 64'(s);
        end
        for (int s = 1; s < SLOTS; s++) visit(1'b1, 1 + (s % 3), 0);
        checkOutput("wrap_head_model", 64'(exp_head[0]), 64'd0);
        // Slot 0 still carries last lap's phase bit: empty now.
        visit(1'b0, 2, 0);
        // CPU writes slot 0 with the new (cleared) phase bit.
        mem_bit[0][0] = 1'b0;
        mem_rpc[0][0] = 64'hB0;
        visit(1'b1, 2, 0);
        start = 1'b0;
        repeat (6) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        resetModel();
        clearMemory();

        // Two flows with three RPCs each, almost-full gating the first read.
        $display("[TB] two flows, almost-full, back-pressure");
        number_of_flows = 1'b1;
        for (int s = 0; s < 3; s++) begin
            mem_bit[0][s] = 1'b1;
            mem_rpc[0][s] = 64'h100 + 64'(s);
            mem_bit[1][s] = 1'b1;
            mem_rpc[1][s] = 64'h200 + 64'(s);
        end
        sRx_c0TxAlmFull = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("almfull_no_read", 64'(sTx_c0.valid), 64'd0);
        end
        sRx_c0TxAlmFull = 1'b0;
        @(negedge clk);
        checkOutput("almfull_release_read", 64'(sTx_c0.valid), 64'd1);
        visit(1'b1, 2, 0);
        visit(1'b1, 3, 0);
        visit(1'b1, 1, 20);
        visit(1'b1, 2, 0);
        visit(1'b1, 4, 0);
        visit(1'b1, 2, 0);
        visit(1'b0, 2, 0);

        // Flow 1 slot 3 read answered with a corrupted tag.
        $display("[TB] wrong mdata and mid-wait reset");
        waitRead(addr, md, ok);
        checkOutput("bad_tag_rd_addr", 64'(addr), 64'h100B);
        @(negedge clk);
        applyStimulus(md ^ 16'h8000, eRSP_RDLINE, 1'b1, 64'hDEAD);
        checkOutput("bad_tag_error", 64'(error), 64'd1);
        checkOutput("bad_tag_no_rpc", 64'(rpc_out_valid), 64'd0);
        ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (sTx_c0.valid) ok = 1'b1;
        end
        checkOutput("bad_tag_stays_waiting", 64'(ok), 64'd0);
        checkOutput("bad_tag_error_sticky", 64'(error), 64'd1);
        // Asynchronous reset while the read is still outstanding.
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("async_rst_tx_valid", 64'(sTx_c0.valid),    64'd0);
        checkOutput("async_rst_tx_hdr",   64'(sTx_c0.hdr),      64'd0);
        checkOutput("async_rst_rpc_out",  64'(rpc_out),        64'd0);
        checkOutput("async_rst_flow_id",  64'(rpc_flow_id_out), 64'd0);
        checkOutput("async_rst_error",    64'(error),           64'd0);
        start = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        resetModel();
        clearMemory();
        @(negedge clk);

        // Responses while idle: UMSG is ignored, RDLINE is an error.
        $display("[TB] unsolicited responses");
        applyStimulus(16'h0000, eRSP_UMSG, 1'b1, 64'h1);
        checkOutput("umsg_ignored", 64'(error), 64'd0);
        applyStimulus(16'h0000, eRSP_RDLINE, 1'b1, 64'h2);
        checkOutput("unsolicited_error", 64'(error), 64'd1);
        checkOutput("unsolicited_no_rpc", 64'(rpc_out_valid), 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("unsolicited_idle_no_read", 64'(sTx_c0.valid), 64'd0);
        number_of_flows = '0;
        start = 1'b1;
        visit(1'b0, 2, 0);
        checkOutput("error_sticky_after_visit", 64'(error), 64'd1);
        start = 1'b0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
